cu_fetch_arbiter: RTL

CU_FETCH_ARBITER -- requirements
Module: cu_fetch_arbiter

---
 rtl/cu_fetch_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/cu_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// cu_fetch_arbiter
//
// Shares one instruction-memory port between NUM_REQ core fetch units.
// A winner is picked combinationally every cycle. On a memory handshake the
// winner's index is pushed into an in-order ID FIFO. Each returning
// mem_r_valid pops the head ID and routes the valid pulse to that core in the
// same cycle. Read data is broadcast to every core unchanged.
//
// Build option:
//   CU_FETCH_ARB_FIXED_PRIO_EN  - when defined, the lowest requesting index
//                                 always wins and no round-robin pointer
//                                 exists. When undefined (default), the
//                                 search starts at a round-robin pointer
//                                 that advances past each granted core.
//
// Parameters:
//   NUM_REQ  number of core requesters (2..8)
//   MAX_OUT  depth of the outstanding-fetch ID FIFO (power of 2, >= 2)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   core_fetch_req        per-core fetch request
//   core_fetch_addr       per-core 19-bit fetch byte address
//   core_fetch_gnt        one-hot (or zero) grant, asserted on handshake
//   core_fetch_r_data     read data, broadcast to all cores
//   core_fetch_r_valid    one-hot (or zero) read-data valid
//   mem_req, mem_addr     request and address toward instruction memory
//   mem_gnt               memory accepts the request this cycle
//   mem_r_data            memory read data
//   mem_r_valid           memory read data valid (responses in request order)
//   outstanding           current ID FIFO occupancy
//   resp_err              sticky: a response arrived with no fetch outstanding
// ---------------------------------------------------------------------------
module cu_fetch_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MAX_OUT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       core_fetch_req,
    input  logic [NUM_REQ-1:0][18:0] core_fetch_addr,
    output logic [NUM_REQ-1:0]       core_fetch_gnt,
    output logic [31:0]              core_fetch_r_data,
    output logic [NUM_REQ-1:0]       core_fetch_r_valid,
    output logic                     mem_req,
    output logic [18:0]              mem_addr,
    input  logic                     mem_gnt,
    input  logic [31:0]              mem_r_data,
    input  logic                     mem_r_valid,
    output logic [$clog2(MAX_OUT):0] outstanding,
    output logic                     resp_err
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(MAX_OUT);

    localparam logic [PTR_W:0] PTR_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(MAX_OUT);

    // -----------------------------------------------------------------------
    // ID FIFO state. Pointers carry one extra wrap bit so that their
    // difference is the occupancy and full/empty need no separate flag.
    // -----------------------------------------------------------------------
    logic [PTR_W:0]  wr_ptr;
    logic [PTR_W:0]  rd_ptr;
    logic [PTR_W:0]  count;
    logic [ID_W-1:0] id_mem [MAX_OUT];
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic [ID_W-1:0] sel;
    logic [ID_W-1:0] head_id;

    assign count      = wr_ptr - rd_ptr;
    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign head_id    = id_mem[rd_ptr[PTR_W-1:0]];

    // -----------------------------------------------------------------------
    // Winner selection
    // -----------------------------------------------------------------------
`ifdef CU_FETCH_ARB_FIXED_PRIO_EN
    // Scan from the top down so the lowest requesting index is written last.
    always_comb begin
        sel = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (core_fetch_req[i]) begin
                sel = ID_W'(i);
            end
        end
    end
`else
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] idx;
    logic            found;

    // NOTE: combinational logic uses blocking assignments with every output
    // given a default first, so no path leaves a value held (no latch).
    always_comb begin
        sel   = rr_ptr;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && core_fetch_req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    // Pointer moves one past the granted core; idle cycles leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (push) begin
            rr_ptr <= (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + ID_W'(1);
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Request side. A full FIFO blocks issue even when a pop happens in the
    // same cycle, which keeps mem_req free of the mem_r_valid path.
    // -----------------------------------------------------------------------
    assign mem_req  = rst_n & (|core_fetch_req) & ~fifo_full;
    assign mem_addr = mem_req ? core_fetch_addr[sel] : '0;
    assign push     = mem_req & mem_gnt;

    always_comb begin
        core_fetch_gnt = '0;
        if (push) begin
            core_fetch_gnt[sel] = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Response side: zero-latency routing of mem_r_valid to the head ID.
    // -----------------------------------------------------------------------
    assign pop               = rst_n & mem_r_valid & ~fifo_empty;
    assign core_fetch_r_data = mem_r_data;

    always_comb begin
        core_fetch_r_valid = '0;
        if (pop) begin
            core_fetch_r_valid[head_id] = 1'b1;
        end
    end

    assign outstanding = count;

    // -----------------------------------------------------------------------
    // FIFO pointers and sticky error flag
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            resp_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (mem_r_valid && fifo_empty) begin
                resp_err <= 1'b1;
            end
        end
    end

    // NOTE: the ID storage has no reset; an entry is only read after it has
    // been written, because occupancy is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr[PTR_W-1:0]] <= sel;
        end
    end

endmodule
